// File: rtl/pc060hb_mailbox_if.sv
// pc060hb_mailbox_if: one CPU-side bus port of the mailbox.
// Instantiate once for the master CPU and once for the sound CPU.
interface pc060hb_mailbox_if #(
  parameter int DW = 8
);
  logic          CS;
  logic          RD;
  logic          WR;
  logic          A0;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;

  modport master (
    output CS, RD, WR, A0, DIN,
    input  DOUT
  );

  modport slave (
    input  CS, RD, WR, A0, DIN,
    output DOUT
  );
endinterface

// File: rtl/pc060hb_mailbox.sv
// pc060hb_mailbox: two-bank master/sound-CPU mailbox with flags and NMI.
// Define MBOX_MASTER_IRQ_EN to add the M_IRQ output and irq_en register.
module pc060hb_mailbox #(
  parameter int DW    = 8,
  parameter int SLOTS = 4,
  parameter int GROUP = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  pc060hb_mailbox_if.slave m_bus,
  pc060hb_mailbox_if.slave s_bus,
  input  logic [1:0]       GPI,
  output logic             NMI_n,
  output logic             AMP,
`ifdef MBOX_MASTER_IRQ_EN
  output logic             M_IRQ,
`endif
  output logic             SUB_RESET
);
  localparam int NG = SLOTS / GROUP;
  localparam int SW = $clog2(SLOTS);
  localparam int IW = SW + 1;
  localparam logic [IW-1:0] IDX_STAT = IW'(SLOTS);
  localparam logic [IW-1:0] IDX_CTRL = IW'(SLOTS + 1);

  logic [IW-1:0] m_idx;
  logic [IW-1:0] s_idx;
  logic [DW-1:0] m2s [SLOTS];
  logic [DW-1:0] s2m [SLOTS];
  logic [NG-1:0] m2s_full;
  logic [NG-1:0] s2m_full;
  logic          m_ovf;
  logic          s_ovf;
  logic          nmi_en;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] s_dout;
`ifdef MBOX_MASTER_IRQ_EN
  logic          irq_en;
`endif

  // Per-slot group mask and "last slot of its group" marker
  logic [NG-1:0]    grp_of [SLOTS];
  logic [SLOTS-1:0] last_of;

  for (genvar s = 0; s < SLOTS; s++) begin : g_map
    assign grp_of[s]  = NG'(1) << (s / GROUP);
    assign last_of[s] = (s % GROUP) == (GROUP - 1);
  end

  logic m_wr;
  logic m_rd;
  logic s_wr;
  logic s_rd;

  assign m_wr = m_bus.CS & m_bus.WR;
  assign m_rd = m_bus.CS & m_bus.RD & ~m_bus.WR;
  assign s_wr = ~SUB_RESET & s_bus.CS & s_bus.WR;
  assign s_rd = ~SUB_RESET & s_bus.CS & s_bus.RD & ~s_bus.WR;

  logic [SW-1:0] m_slot;
  logic [SW-1:0] s_slot;
  logic          m_mbx;
  logic          s_mbx;
  logic          m_stat;
  logic          s_stat;
  logic          s_ctrl;

  assign m_slot = m_idx[SW-1:0];
  assign s_slot = s_idx[SW-1:0];
  assign m_mbx  = m_bus.A0 & ~m_idx[IW-1];
  assign s_mbx  = s_bus.A0 & ~s_idx[IW-1];
  assign m_stat = m_bus.A0 & (m_idx == IDX_STAT);
  assign s_stat = s_bus.A0 & (s_idx == IDX_STAT);
  assign s_ctrl = s_bus.A0 & (s_idx == IDX_CTRL);

`ifdef MBOX_MASTER_IRQ_EN
  logic m_ctrl;
  assign m_ctrl = m_bus.A0 & (m_idx == IDX_CTRL);
`endif

  logic [NG-1:0] m2s_set;
  logic [NG-1:0] m2s_clr;
  logic [NG-1:0] s2m_set;
  logic [NG-1:0] s2m_clr;
  logic          m_ovf_set;
  logic          s_ovf_set;

  assign m2s_set = (m_wr & m_mbx & last_of[m_slot]) ?
                   grp_of[m_slot] : '0;
  assign m2s_clr = (s_rd & s_mbx & last_of[s_slot]) ?
                   grp_of[s_slot] : '0;
  assign s2m_set = (s_wr & s_mbx & last_of[s_slot]) ?
                   grp_of[s_slot] : '0;
  assign s2m_clr = (m_rd & m_mbx & last_of[m_slot]) ?
                   grp_of[m_slot] : '0;

  assign m_ovf_set = m_wr & m_mbx &
                     (|(m2s_full & grp_of[m_slot]));
  assign s_ovf_set = s_wr & s_mbx &
                     (|(s2m_full & grp_of[s_slot]));

  logic [DW-1:0] m_stat_word;
  logic [DW-1:0] s_stat_word;

  assign m_stat_word = DW'({m_ovf, m2s_full, s2m_full});
  assign s_stat_word = DW'({s_ovf, m2s_full, s2m_full});

  logic [DW-1:0] m_rdata;
  logic [DW-1:0] s_rdata;

  always_comb begin
    m_rdata = '0;
    unique case (1'b1)
      ~m_bus.A0: m_rdata = DW'(m_idx);
      m_mbx:     m_rdata = s2m[m_slot];
      m_stat:    m_rdata = m_stat_word;
`ifdef MBOX_MASTER_IRQ_EN
      m_ctrl:    m_rdata = DW'(irq_en);
`endif
      default:   m_rdata = '0;
    endcase
  end

  always_comb begin
    s_rdata = '0;
    unique case (1'b1)
      ~s_bus.A0: s_rdata = DW'(s_idx);
      s_mbx:     s_rdata = m2s[s_slot];
      s_stat:    s_rdata = s_stat_word;
      s_ctrl:    s_rdata = DW'(GPI);
      default:   s_rdata = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_idx     <= '0;
      m_dout    <= '0;
      m_ovf     <= 1'b0;
      SUB_RESET <= 1'b0;
    end else begin
      if (m_rd)
        m_dout <= m_rdata;
      if (m_wr & ~m_bus.A0)
        m_idx <= m_bus.DIN[IW-1:0];
      else if ((m_wr | m_rd) & m_mbx)
        m_idx <= {1'b0, m_slot + SW'(1)};
      if (m_wr & m_stat)
        SUB_RESET <= m_bus.DIN[0];
      if (m_ovf_set)
        m_ovf <= 1'b1;
      else if (m_rd & m_stat)
        m_ovf <= 1'b0;
    end
  end

`ifdef MBOX_MASTER_IRQ_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_en <= 1'b0;
      M_IRQ  <= 1'b0;
    end else begin
      if (m_wr & m_ctrl)
        irq_en <= m_bus.DIN[0];
      M_IRQ <= irq_en & (|s2m_full);
    end
  end
`endif

  // Slave-owned state is pinned to reset while SUB_RESET is high
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s_idx  <= '0;
      s_ovf  <= 1'b0;
      AMP    <= 1'b0;
      nmi_en <= 1'b0;
    end else if (SUB_RESET) begin
      s_idx  <= '0;
      s_ovf  <= 1'b0;
      AMP    <= 1'b0;
      nmi_en <= 1'b0;
    end else begin
      if (s_wr & ~s_bus.A0)
        s_idx <= s_bus.DIN[IW-1:0];
      else if ((s_wr | s_rd) & s_mbx)
        s_idx <= {1'b0, s_slot + SW'(1)};
      if (s_wr & s_stat)
        AMP <= s_bus.DIN[0];
      if (s_wr & s_ctrl)
        nmi_en <= s_bus.DIN[0];
      if (s_ovf_set)
        s_ovf <= 1'b1;
      else if (s_rd & s_stat)
        s_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      s_dout <= '0;
    else if (s_rd)
      s_dout <= s_rdata;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m2s_full <= '0;
      s2m_full <= '0;
    end else if (SUB_RESET) begin
      m2s_full <= '0;
      s2m_full <= '0;
    end else begin
      m2s_full <= (m2s_full & ~m2s_clr) | m2s_set;
      s2m_full <= (s2m_full & ~s2m_clr) | s2m_set;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < SLOTS; i++) begin
        m2s[i] <= '0;
        s2m[i] <= '0;
      end
    end else begin
      if (m_wr & m_mbx)
        m2s[m_slot] <= m_bus.DIN;
      if (s_wr & s_mbx)
        s2m[s_slot] <= s_bus.DIN;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      NMI_n <= 1'b1;
    else
      NMI_n <= ~(nmi_en & (|m2s_full));
  end

  assign m_bus.DOUT = m_dout;
  assign s_bus.DOUT = s_dout;
endmodule

// File: tb/tb_pc060hb_mailbox.sv
// tb_pc060hb_mailbox: vector table, corner sequences and a random run
// checked against a slot/flag-level model of the mailbox.
module tb_pc060hb_mailbox;
  localparam int DW = 8;

  typedef struct packed {
    logic       cs;
    logic       rd;
    logic       wr;
    logic       a0;
    logic [7:0] din;
  } op_t;

  typedef struct {
    op_t        m;
    op_t        s;
    logic [7:0] md;
    logic [7:0] sd;
    logic       nmi;
    logic       amp;
    logic       sub;
  } vec_t;

  logic       CLK;
  logic       RESET;
  logic [1:0] GPI;
  logic       NMI_n;
  logic       AMP;
  logic       SUB_RESET;
`ifdef MBOX_MASTER_IRQ_EN
  logic       M_IRQ;
`endif

  pc060hb_mailbox_if #(.DW(DW)) m_bus ();
  pc060hb_mailbox_if #(.DW(DW)) s_bus ();

  pc060hb_mailbox #(.DW(DW), .SLOTS(4), .GROUP(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .m_bus     (m_bus),
    .s_bus     (s_bus),
    .GPI       (GPI),
    .NMI_n     (NMI_n),
    .AMP       (AMP),
`ifdef MBOX_MASTER_IRQ_EN
    .M_IRQ     (M_IRQ),
`endif
    .SUB_RESET (SUB_RESET)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic op_t idle();
    return op_t'(12'h000);
  endfunction
  function automatic op_t iw(logic [7:0] d);
    return op_t'({4'b1010, d});
  endfunction
  function automatic op_t dw(logic [7:0] d);
    return op_t'({4'b1011, d});
  endfunction
  function automatic op_t ir();
    return op_t'({4'b1100, 8'h00});
  endfunction
  function automatic op_t dr();
    return op_t'({4'b1101, 8'h00});
  endfunction

  function automatic vec_t mk(op_t m, op_t s, logic [7:0] md,
                              logic [7:0] sd, logic n, logic a,
                              logic r);
    vec_t v;
    v.m = m; v.s = s; v.md = md; v.sd = sd;
    v.nmi = n; v.amp = a; v.sub = r;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(string tag, logic [7:0] md, logic [7:0] sd,
                          logic n, logic a, logic r);
    chk({tag, " M_DOUT"}, 32'(m_bus.DOUT), 32'(md));
    chk({tag, " S_DOUT"}, 32'(s_bus.DOUT), 32'(sd));
    chk({tag, " NMI_n"}, 32'(NMI_n), 32'(n));
    chk({tag, " AMP"}, 32'(AMP), 32'(a));
    chk({tag, " SUB_RESET"}, 32'(SUB_RESET), 32'(r));
  endtask

  task automatic drive(op_t m, op_t s, logic [1:0] g);
    m_bus.CS = m.cs; m_bus.RD = m.rd; m_bus.WR = m.wr;
    m_bus.A0 = m.a0; m_bus.DIN = m.din;
    s_bus.CS = s.cs; s_bus.RD = s.rd; s_bus.WR = s.wr;
    s_bus.A0 = s.a0; s_bus.DIN = s.din;
    GPI = g;
    @(posedge CLK);
    #1;
  endtask

  // Behavioural model: slot arrays, per-group flags, plain int indices
  int         mi, si;
  logic [7:0] mm2s [4];
  logic [7:0] ms2m [4];
  bit         mf [2];
  bit         sf [2];
  bit         m_ov, s_ov, sub, amp_q, nmie, irqe;
  logic [7:0] md, sd;
  bit         nmi_q, irq_q;

  task automatic model_reset();
    mi = 0; si = 0;
    for (int i = 0; i < 4; i++) begin
      mm2s[i] = 8'h00; ms2m[i] = 8'h00;
    end
    mf[0] = 0; mf[1] = 0; sf[0] = 0; sf[1] = 0;
    m_ov = 0; s_ov = 0; sub = 0; amp_q = 0; nmie = 0; irqe = 0;
    md = 8'h00; sd = 8'h00; nmi_q = 1; irq_q = 0;
  endtask

  function automatic logic [7:0] status(bit ov);
    return 8'(int'(sf[0]) + 2 * int'(sf[1]) + 4 * int'(mf[0]) +
              8 * int'(mf[1]) + 16 * int'(ov));
  endfunction

  task automatic model_step(op_t m, op_t s, logic [1:0] g);
    logic [7:0] om2s [4];
    logic [7:0] os2m [4];
    bit  mset [2];
    bit  mclr [2];
    bit  sset [2];
    bit  sclr [2];
    bit  mov_set, mov_clr, sov_set, sov_clr;
    bit  nmi_nx, irq_nx, sub_n, amp_n, nmie_n, irqe_n;
    int  mi_n, si_n;
    logic [7:0] md_n, sd_n;
    for (int i = 0; i < 4; i++) begin
      om2s[i] = mm2s[i]; os2m[i] = ms2m[i];
    end
    for (int k = 0; k < 2; k++) begin
      mset[k] = 0; mclr[k] = 0; sset[k] = 0; sclr[k] = 0;
    end
    mov_set = 0; mov_clr = 0; sov_set = 0; sov_clr = 0;
    nmi_nx = !(nmie && (mf[0] || mf[1]));
    irq_nx = irqe && (sf[0] || sf[1]);
    sub_n = sub; amp_n = amp_q; nmie_n = nmie; irqe_n = irqe;
    mi_n = mi; si_n = si; md_n = md; sd_n = sd;
    if (m.cs && m.wr) begin
      if (!m.a0) mi_n = int'(m.din) % 8;
      else if (mi < 4) begin
        if (mf[mi / 2]) mov_set = 1;
        mm2s[mi] = m.din;
        if (mi % 2 == 1) mset[mi / 2] = 1;
        mi_n = (mi + 1) % 4;
      end else if (mi == 4) sub_n = m.din[0];
`ifdef MBOX_MASTER_IRQ_EN
      else if (mi == 5) irqe_n = m.din[0];
`endif
    end else if (m.cs && m.rd) begin
      if (!m.a0) md_n = 8'(mi);
      else if (mi < 4) begin
        md_n = os2m[mi];
        if (mi % 2 == 1) sclr[mi / 2] = 1;
        mi_n = (mi + 1) % 4;
      end else if (mi == 4) begin
        md_n = status(m_ov); mov_clr = 1;
      end else if (mi == 5) begin
`ifdef MBOX_MASTER_IRQ_EN
        md_n = 8'(irqe);
`else
        md_n = 8'h00;
`endif
      end else md_n = 8'h00;
    end
    if (!sub && s.cs && s.wr) begin
      if (!s.a0) si_n = int'(s.din) % 8;
      else if (si < 4) begin
        if (sf[si / 2]) sov_set = 1;
        ms2m[si] = s.din;
        if (si % 2 == 1) sset[si / 2] = 1;
        si_n = (si + 1) % 4;
      end else if (si == 4) amp_n = s.din[0];
      else if (si == 5) nmie_n = s.din[0];
    end else if (!sub && s.cs && s.rd) begin
      if (!s.a0) sd_n = 8'(si);
      else if (si < 4) begin
        sd_n = om2s[si];
        if (si % 2 == 1) mclr[si / 2] = 1;
        si_n = (si + 1) % 4;
      end else if (si == 4) begin
        sd_n = status(s_ov); sov_clr = 1;
      end else if (si == 5) sd_n = 8'(g);
      else sd_n = 8'h00;
    end
    for (int k = 0; k < 2; k++) begin
      mf[k] = !sub && ((mf[k] && !mclr[k]) || mset[k]);
      sf[k] = !sub && ((sf[k] && !sclr[k]) || sset[k]);
    end
    m_ov = mov_set || (m_ov && !mov_clr);
    s_ov = !sub && (sov_set || (s_ov && !sov_clr));
    if (sub) begin
      si_n = 0; amp_n = 0; nmie_n = 0;
    end
    mi = mi_n; si = si_n; md = md_n; sd = sd_n;
    amp_q = amp_n; nmie = nmie_n; irqe = irqe_n; sub = sub_n;
    nmi_q = nmi_nx; irq_q = irq_nx;
  endtask

  function automatic op_t rnd_op();
    op_t o;
    int  r;
    o = idle();
    r = $urandom_range(0, 9);
    if (r >= 2) o.cs = 1'b1;
    case (r)
      2, 3: begin
        o.wr = 1'b1; o.din = 8'($urandom_range(0, 6));
      end
      4, 5, 6: begin
        o.wr = 1'b1; o.a0 = 1'b1; o.din = 8'($urandom);
      end
      7, 8: begin
        o.rd = 1'b1; o.a0 = 1'b1;
      end
      9: o.rd = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  vec_t tbl [$];

  initial begin
    RESET = 1'b1;
    m_bus.CS = 0; m_bus.RD = 0; m_bus.WR = 0; m_bus.A0 = 0;
    m_bus.DIN = 0;
    s_bus.CS = 0; s_bus.RD = 0; s_bus.WR = 0; s_bus.A0 = 0;
    s_bus.DIN = 0;
    GPI = 2'b10;

    tbl.push_back(mk(iw(0),   iw(5),   8'h00, 8'h00, 1, 0, 0));
    tbl.push_back(mk(dw(8'h11), dw(1), 8'h00, 8'h00, 1, 0, 0));
    tbl.push_back(mk(dw(8'h22), iw(0), 8'h00, 8'h00, 1, 0, 0));
    tbl.push_back(mk(idle(),  idle(),  8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(idle(),  dr(),    8'h00, 8'h11, 0, 0, 0));
    tbl.push_back(mk(idle(),  dr(),    8'h00, 8'h22, 0, 0, 0));
    tbl.push_back(mk(idle(),  idle(),  8'h00, 8'h22, 1, 0, 0));
    tbl.push_back(mk(idle(),  iw(4),   8'h00, 8'h22, 1, 0, 0));
    tbl.push_back(mk(idle(),  dw(1),   8'h00, 8'h22, 1, 1, 0));
    tbl.push_back(mk(iw(0),   idle(),  8'h00, 8'h22, 1, 1, 0));
    tbl.push_back(mk(dw(8'hA0), idle(), 8'h00, 8'h22, 1, 1, 0));
    tbl.push_back(mk(dw(8'hA1), idle(), 8'h00, 8'h22, 1, 1, 0));
    tbl.push_back(mk(dw(8'hA2), idle(), 8'h00, 8'h22, 0, 1, 0));
    tbl.push_back(mk(dw(8'hA3), idle(), 8'h00, 8'h22, 0, 1, 0));
    tbl.push_back(mk(dw(8'hB0), idle(), 8'h00, 8'h22, 0, 1, 0));
    tbl.push_back(mk(ir(),    idle(),  8'h01, 8'h22, 0, 1, 0));
    tbl.push_back(mk(iw(4),   idle(),  8'h01, 8'h22, 0, 1, 0));
    tbl.push_back(mk(dr(),    idle(),  8'h1C, 8'h22, 0, 1, 0));
    tbl.push_back(mk(dr(),    idle(),  8'h0C, 8'h22, 0, 1, 0));
    tbl.push_back(mk(iw(1),   iw(1),   8'h0C, 8'h22, 0, 1, 0));
    tbl.push_back(mk(dw(8'h55), dr(),  8'h0C, 8'hA1, 0, 1, 0));
    tbl.push_back(mk(iw(4),   idle(),  8'h0C, 8'hA1, 0, 1, 0));
    tbl.push_back(mk(dr(),    idle(),  8'h1C, 8'hA1, 0, 1, 0));
    tbl.push_back(mk(dw(1),   idle(),  8'h1C, 8'hA1, 0, 1, 1));
    tbl.push_back(mk(idle(),  idle(),  8'h1C, 8'hA1, 0, 0, 1));
    tbl.push_back(mk(idle(),  dw(8'h77), 8'h1C, 8'hA1, 1, 0, 1));
    tbl.push_back(mk(dw(0),   idle(),  8'h1C, 8'hA1, 1, 0, 0));
    tbl.push_back(mk(idle(),  dr(),    8'h1C, 8'hB0, 1, 0, 0));
    tbl.push_back(mk(iw(0),   idle(),  8'h1C, 8'hB0, 1, 0, 0));
    tbl.push_back(mk(dr(),    idle(),  8'h00, 8'hB0, 1, 0, 0));
    tbl.push_back(mk(iw(4),   iw(5),   8'h00, 8'hB0, 1, 0, 0));
    tbl.push_back(mk(dr(),    dr(),    8'h00, 8'h02, 1, 0, 0));
    tbl.push_back(mk(ir(),    idle(),  8'h04, 8'h02, 1, 0, 0));
    tbl.push_back(mk(iw(6),   idle(),  8'h04, 8'h02, 1, 0, 0));
    tbl.push_back(mk(dw(8'hFF), idle(), 8'h04, 8'h02, 1, 0, 0));
    tbl.push_back(mk(dr(),    idle(),  8'h00, 8'h02, 1, 0, 0));

    repeat (2) @(posedge CLK);
    #1;
    chk_outs("reset", 8'h00, 8'h00, 1, 0, 0);
    RESET = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].m, tbl[i].s, 2'b10);
      chk_outs($sformatf("vec%0d", i), tbl[i].md, tbl[i].sd,
               tbl[i].nmi, tbl[i].amp, tbl[i].sub);
    end

    // Random traffic from a freshly reset DUT and model
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      op_t      mo;
      op_t      so;
      logic [1:0] g;
      mo = rnd_op();
      so = rnd_op();
      g  = 2'($urandom_range(0, 3));
      model_step(mo, so, g);
      drive(mo, so, g);
      chk_outs($sformatf("rnd%0d", n), md, sd, nmi_q, amp_q, sub);
`ifdef MBOX_MASTER_IRQ_EN
      chk($sformatf("rnd%0d M_IRQ", n), 32'(M_IRQ), 32'(irq_q));
`endif
    end

    // Build up visible state, then reset in the middle of an access
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    drive(iw(3),  iw(0),     2'b00);
    drive(idle(), dw(8'h5A), 2'b00);
    drive(idle(), dw(8'h5B), 2'b00);
    drive(ir(),   iw(4),     2'b00);
    drive(idle(), dw(1),     2'b00);
    drive(idle(), ir(),      2'b00);
    chk_outs("pre_rst", 8'h03, 8'h04, 1, 1, 0);
    m_bus.CS = 1; m_bus.WR = 1; m_bus.RD = 0; m_bus.A0 = 1;
    m_bus.DIN = 8'h99;
    #3;
    RESET = 1'b1;
    #1;
    chk_outs("mid_rst", 8'h00, 8'h00, 1, 0, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    drive(ir(),   ir(),   2'b00);
    chk_outs("idx_after_rst", 8'h00, 8'h00, 1, 0, 0);
    drive(iw(4),  iw(4),  2'b00);
    drive(dr(),   dr(),   2'b00);
    chk_outs("stat_after_rst", 8'h00, 8'h00, 1, 0, 0);
    drive(iw(0),  iw(3),  2'b00);
    drive(dr(),   dr(),   2'b00);
    chk_outs("slot_after_rst", 8'h00, 8'h00, 1, 0, 0);

`ifdef MBOX_MASTER_IRQ_EN
    drive(iw(5),  iw(2),     2'b00);
    drive(dw(1),  dw(8'h31), 2'b00);
    chk("irq_en wr", 32'(M_IRQ), 32'd0);
    drive(dr(),   dw(8'h32), 2'b00);
    chk("irq_en rd", 32'(m_bus.DOUT), 32'd1);
    chk("irq set edge", 32'(M_IRQ), 32'd0);
    drive(iw(3),  idle(),    2'b00);
    chk("irq raised", 32'(M_IRQ), 32'd1);
    drive(dr(),   idle(),    2'b00);
    chk("irq slot3", 32'(m_bus.DOUT), 32'h32);
    drive(idle(), idle(),    2'b00);
    chk("irq dropped", 32'(M_IRQ), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
